// File: rtl/uart_tx_if.sv
// Byte-in / serial-out signal bundle for uart_tx.
// The master side writes bytes and supplies the baud tick; the slave side is the transmitter.
interface uart_tx_if #(
    parameter int DBits = 8
);
    logic             tx_tick;
    logic             tx_start;
    logic [DBits-1:0] tx_din;
    logic             tx_ready;
    logic             tx;
    logic             tx_busy;
    logic             tx_done;

    modport master (
        output tx_tick, tx_start, tx_din,
        input  tx_ready, tx, tx_busy, tx_done
    );

    modport slave (
        input  tx_tick, tx_start, tx_din,
        output tx_ready, tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBits data bits LSB first, optional parity, 1..2 stop bits.
// A one-byte holding register lets the next frame follow the current one with no idle tick.
module uart_tx #(
    parameter int DBits      = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic     PCLK,
    input  logic     PRESET,
    uart_tx_if.slave bus
);
    localparam int BW = $clog2(DBits);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [DBits-1:0] hold_q, hold_d;
    logic [DBits-1:0] shreg_q, shreg_d;
    logic             pend_q, pend_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic             stopcnt_q, stopcnt_d;
    logic             stop_last;

    assign stop_last = (stopcnt_q == 1'(STOP_BITS - 1));

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        shreg_d   = shreg_q;
        pend_d    = pend_q;
        par_d     = par_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        bitcnt_d  = bitcnt_q;
        stopcnt_d = stopcnt_q;

        if (bus.tx_start && !pend_q) begin
            hold_d = bus.tx_din;
            pend_d = 1'b1;
        end

        if (bus.tx_tick) begin
            case (state_q)
                IDLE: tx_d = 1'b1;
                START: begin
                    tx_d     = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = '0;
                    state_d  = DATA;
                end
                DATA: begin
                    if (bitcnt_q == BW'(DBits - 1)) begin
                        if (PARITY_EN != 0) begin
                            tx_d    = par_q;
                            state_d = PARITY;
                        end else begin
                            tx_d      = 1'b1;
                            stopcnt_d = 1'b0;
                            state_d   = STOP;
                        end
                    end else begin
                        tx_d     = shreg_q[0];
                        shreg_d  = shreg_q >> 1;
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    tx_d      = 1'b1;
                    stopcnt_d = 1'b0;
                    state_d   = STOP;
                end
                STOP: begin
                    if (stop_last) begin
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stopcnt_d = stopcnt_q + 1'b1;
                    end
                end
                default: begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            endcase

            // A queued byte overrides the IDLE/STOP outcome above so the start bit follows the last stop bit directly.
            if (pend_q && (state_q == IDLE || (state_q == STOP && stop_last))) begin
                tx_d    = 1'b0;
                shreg_d = hold_q;
                par_d   = (^hold_q) ^ (PARITY_ODD != 0);
                pend_d  = 1'b0;
                state_d = START;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            shreg_q   <= '0;
            pend_q    <= 1'b0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            bitcnt_q  <= '0;
            stopcnt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shreg_q   <= shreg_d;
            pend_q    <= pend_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            bitcnt_q  <= bitcnt_d;
            stopcnt_q <= stopcnt_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_done  = done_q;
    assign bus.tx_ready = !pend_q;
    assign bus.tx_busy  = (state_q != IDLE) | pend_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations share one stimulus stream; a tick-level model schedules
// each accepted byte, and a line monitor decodes frames and scores them against that schedule.
module tb_uart_tx;
    localparam int D = 8;

    logic         PCLK   = 1'b0;
    logic         PRESET = 1'b1;
    logic         tick   = 1'b0;
    logic [2:0]   start  = '0;
    logic [D-1:0] din    = '0;
    logic [2:0]   txw, rdy, bsy, dn;

    always #5 PCLK = ~PCLK;

    uart_tx_if #(.DBits(D)) bus0 ();
    uart_tx_if #(.DBits(D)) bus1 ();
    uart_tx_if #(.DBits(D)) bus2 ();

    assign bus0.tx_tick = tick;  assign bus0.tx_start = start[0];  assign bus0.tx_din = din;
    assign bus1.tx_tick = tick;  assign bus1.tx_start = start[1];  assign bus1.tx_din = din;
    assign bus2.tx_tick = tick;  assign bus2.tx_start = start[2];  assign bus2.tx_din = din;

    assign txw = {bus2.tx, bus1.tx, bus0.tx};
    assign rdy = {bus2.tx_ready, bus1.tx_ready, bus0.tx_ready};
    assign bsy = {bus2.tx_busy, bus1.tx_busy, bus0.tx_busy};
    assign dn  = {bus2.tx_done, bus1.tx_done, bus0.tx_done};

    uart_tx #(.DBits(D), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0))
        dut0 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus0));
    uart_tx #(.DBits(D), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0))
        dut1 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus1));
    uart_tx #(.DBits(D), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1))
        dut2 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus2));

    // Frame length in ticks = 1 + D + parity + stop bits, per configuration.
    int flen [3] = '{10, 12, 11};
    int pen  [3] = '{0, 1, 1};
    int podd [3] = '{0, 0, 1};

    typedef struct {
        int           id;
        logic [D-1:0] data;
        int           start;
    } exp_t;
    exp_t expq[$];

    int tc = 0, ph = 0, per = 16;
    bit tick_edge = 1'b0, rst_edge = 1'b0, mon_en = 1'b0;
    bit pend_v [3];
    int pend_start [3];
    int sched [3];
    int sched_prev [3];
    int n_pass = 0, n_tot = 0;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", name, i, $time, act, exp);
    endtask

    function automatic bit m_ready(input int i);
        return !(pend_v[i] && pend_start[i] > tc);
    endfunction

    function automatic bit in_frame(input int i, input int s);
        return (s <= tc) && (tc <= s + flen[i] - 1);
    endfunction

    function automatic bit m_busy(input int i);
        return !m_ready(i) || in_frame(i, sched[i]) || in_frame(i, sched_prev[i]);
    endfunction

    function automatic bit any_busy();
        return m_busy(0) || m_busy(1) || m_busy(2);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            pend_v[i]     = 1'b0;
            pend_start[i] = 0;
            sched[i]      = -1000;
            sched_prev[i] = -1000;
        end
        expq.delete();
    endfunction

    // One PCLK edge. A byte is accepted when the holding slot is free before the edge; its start
    // tick is the first tick after acceptance, but never before the previous frame has ended.
    task automatic cycle(input bit tk, input logic [2:0] st, input logic [D-1:0] d, input bit rst);
        logic [2:0] acc;
        for (int i = 0; i < 3; i++) acc[i] = st[i] && m_ready(i);
        tick   = tk;
        start  = st;
        din    = d;
        PRESET = rst;
        @(posedge PCLK);
        #1;
        if (tk) tc++;
        tick_edge = tk;
        rst_edge  = rst;
        if (rst) model_clear();
        else begin
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    int s;
                    s = (tc + 1 > sched[i] + flen[i]) ? tc + 1 : sched[i] + flen[i];
                    sched_prev[i] = sched[i];
                    sched[i]      = s;
                    pend_v[i]     = 1'b1;
                    pend_start[i] = s;
                    expq.push_back('{i, d, s});
                end
            end
        end
    endtask

    task automatic step(input logic [2:0] st, input logic [D-1:0] d, input bit rst);
        bit tk;
        tk = (ph >= per - 1);
        ph = tk ? 0 : ph + 1;
        cycle(tk, st, d, rst);
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, '0, 1'b0);
    endtask

    task automatic send(input logic [D-1:0] d);
        logic [2:0] sent, st;
        int k;
        sent = '0;
        k    = 0;
        while (sent != 3'b111 && k < 5000) begin
            for (int i = 0; i < 3; i++) st[i] = !sent[i] && m_ready(i);
            step(st, d, 1'b0);
            sent |= st;
            k++;
        end
        chk("send_accepted", 0, {29'd0, sent}, 32'd7);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((expq.size() != 0 || any_busy()) && k < 20000) begin
            idle(1);
            k++;
        end
        chk("idle_reached", 0, {31'd0, k < 20000}, 32'd1);
    endtask

    bit          inf [3];
    bit          hd [3];
    int          pos [3];
    int          cst [3];
    int          dst [3];
    logic [15:0] cap [3];
    logic [15:0] dbits [3];
    logic        ptx [3];

    task automatic score(input int i);
        int   j;
        exp_t e;
        j = -1;
        foreach (expq[k]) if (j < 0 && expq[k].id == i) j = k;
        chk("frame_expected", i, {31'd0, j >= 0}, 32'd1);
        if (j < 0) return;
        e = expq[j];
        expq.delete(j);
        chk("start_bit", i, {31'd0, dbits[i][0]}, 32'd0);
        chk("data", i, {24'd0, dbits[i][D:1]}, {24'd0, e.data});
        if (pen[i] != 0)
            chk("parity", i, {31'd0, dbits[i][D+1]}, ($countones(e.data) + podd[i]) % 2);
        for (int k = 1 + D + pen[i]; k < flen[i]; k++)
            chk("stop_bit", i, {31'd0, dbits[i][k]}, 32'd1);
        chk("start_tick", i, dst[i], e.start);
    endtask

    always @(negedge PCLK) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                if (rst_edge) begin
                    inf[i] = 1'b0;
                    hd[i]  = 1'b0;
                    chk("rst_tx", i, {31'd0, txw[i]}, 32'd1);
                    chk("rst_ready", i, {31'd0, rdy[i]}, 32'd1);
                    chk("rst_busy", i, {31'd0, bsy[i]}, 32'd0);
                    chk("rst_done", i, {31'd0, dn[i]}, 32'd0);
                end else begin
                    chk("ready", i, {31'd0, rdy[i]}, {31'd0, m_ready(i)});
                    chk("busy", i, {31'd0, bsy[i]}, {31'd0, m_busy(i)});
                    chk("done", i, {31'd0, dn[i]}, {31'd0, tick_edge && hd[i]});
                    if (tick_edge && hd[i]) begin
                        hd[i] = 1'b0;
                        score(i);
                    end
                    if (tick_edge) begin
                        if (inf[i]) begin
                            cap[i][pos[i]] = txw[i];
                            pos[i]++;
                            if (pos[i] == flen[i]) begin
                                inf[i]   = 1'b0;
                                hd[i]    = 1'b1;
                                dbits[i] = cap[i];
                                dst[i]   = cst[i];
                            end
                        end else if (txw[i] == 1'b0) begin
                            inf[i]    = 1'b1;
                            cap[i]    = '1;
                            cap[i][0] = 1'b0;
                            pos[i]    = 1;
                            cst[i]    = tc;
                        end
                    end else begin
                        chk("line_stable", i, {31'd0, txw[i]}, {31'd0, ptx[i]});
                    end
                end
                ptx[i] = txw[i];
            end
        end
    end

    initial begin
        int         k;
        logic [2:0] m;
        model_clear();
        step('0, '0, 1'b1);
        mon_en = 1'b1;
        step('0, '0, 1'b1);
        idle(20);

        send(8'hA5);
        wait_idle();

        send(8'h3C);
        send(8'hC3);
        step('1, 8'h55, 1'b0);
        wait_idle();

        send(8'h07);
        wait_idle();

        send(8'hFF);
        k = 0;
        while (tc < sched[0] + 5 && k < 5000) begin
            idle(1);
            k++;
        end
        idle(3);
        step('0, '0, 1'b1);
        idle(5);
        send(8'h81);
        wait_idle();

        while (ph != per - 1) idle(1);
        step('1, 8'h5A, 1'b0);
        wait_idle();

        repeat (4000) begin
            if ($urandom_range(0, 199) == 0) per = $urandom_range(1, 16);
            for (int i = 0; i < 3; i++) m[i] = ($urandom_range(0, 5) == 0);
            step(m, D'($urandom), $urandom_range(0, 999) == 0);
        end

        per = 2;
        wait_idle();
        idle(5);
        chk("drain", 0, expq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Transmit half of the UART, next to the receiver. Consumes `tx_tick` from the baud generator, a one-PCLK pulse at the bit rate.
- Serialises a parallel byte into an 8N1 frame by default: start bit, DBits data bits LSB first, optional parity, 1 or 2 stop bits.
- Holds one byte in a holding register while another shifts, so frames go back-to-back with no idle gap.
- Everything runs on PCLK; `tx_tick` is a clock enable only, never a clock.

Parameters:
- DBits, 8, number of data bits per frame (5..9).
- STOP_BITS, 1, number of stop bits (1 or 2).
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only when PARITY_EN=1).

Ports:
- PCLK  input  1  system clock.
- PRESET  input  1  reset, synchronous to PCLK, active-high.
- tx_tick  input  1  one-PCLK-wide pulse per bit period, from the baud generator.
- tx_start  input  1  write strobe; the byte is accepted when tx_start=1 and tx_ready=1.
- tx_din  input  DBits  byte to send, sampled on accept.
- tx_ready  output  1  holding register empty, can accept a byte.
- tx  output  1  serial line, idle high.
- tx_busy  output  1  frame in progress or byte pending.
- tx_done  output  1  one-PCLK pulse when a frame's last stop bit completes.

Behaviour:
- Reset (PRESET=1 at a PCLK edge) takes effect at that edge. Outputs after reset: tx=1, tx_ready=1, tx_busy=0, tx_done=0. Internal state after reset: state=IDLE, pending=0, counters=0.
- Reset mid-frame aborts the frame: line returns to 1, pending byte is discarded, no tx_done.
- Registered outputs: tx, tx_done.
- Combinational outputs: tx_ready = !pending; tx_busy = (state!=IDLE) | pending.
- Accept: on an edge with tx_start & tx_ready, hold<=tx_din and pending<=1.
  - tx_start while tx_ready=0 is ignored; hold is not overwritten.
  - Accept and tx_tick on the same edge: the accept still occurs. The frame starts at the next tx_tick, never the same one.
- Frame timing: every bit is held exactly one tick interval. A transition happens only on edges where tx_tick=1. Latency from accept to start-bit edge is 1..one bit period (waits for the next tick).
- State machine (all transitions qualified by tx_tick):
  - IDLE: tx=1. If pending: tx<=0, shreg<=hold, par<=(^hold)^PARITY_ODD, pending<=0, goto START.
  - START: tx<=shreg[0], shreg>>=1, bitcnt<=0, goto DATA.
  - DATA: if bitcnt==DBits-1: goto PARITY (tx<=par) when PARITY_EN, else goto STOP (tx<=1, stopcnt<=0). Otherwise tx<=shreg[0], shreg>>=1, bitcnt++.
  - PARITY: tx<=1, stopcnt<=0, goto STOP.
  - STOP: if stopcnt==STOP_BITS-1: tx_done<=1 for one PCLK. Then, if pending, take the IDLE-with-pending actions and goto START (back-to-back frame); else goto IDLE. Otherwise stopcnt++.
- tx_ready rises on the edge where the pending byte moves into shreg; a new byte can then be written during the current frame.
- Frame length in ticks: 1 + DBits + PARITY_EN + STOP_BITS (10 for defaults).
- Counters: bitcnt is clog2(DBits) bits wide; stopcnt is 1 bit; no wrap beyond the limits above.

Test Plan:
- Reset, write 0xA5, tx_tick every 16 PCLK:
  - tx per tick = 0,1,0,1,0,0,1,0,1,1.
  - tx_done pulses once, 10 ticks after start, for exactly 1 PCLK.
  - tx_busy falls with it.
- Write 0x3C, then write 0xC3 as soon as tx_ready rises:
  - Second start bit immediately follows the first stop bit, no idle tick.
  - Two tx_done pulses, 10 ticks apart.
- Write 0x55 while tx_ready=0 (two bytes already queued): third write ignored; line shows only the two queued frames.
- PARITY_EN=1:
  - PARITY_ODD=0: 0x07 -> parity bit 1.
  - PARITY_ODD=1: 0x07 -> parity bit 0.
  - STOP_BITS=2: frame = 12 ticks, line high for the last 2.
- Assert PRESET during data bit 4 of 0xFF: next edge tx=1, tx_ready=1, tx_busy=0, no tx_done. A fresh 0x81 then transmits correctly.
- tx_start coincident with tx_tick in IDLE: start bit appears at the following tick, not the same edge.
